registers_bank_dump_ctrl: RTL and testbench

Debug-side controller for the ID-stage register bank. On a start request it stalls the pipeline and takes over bank read port A. It then reads every register in ascending address order and serialises each word as bytes, LSB first, over a valid/ready byte stream to the debug unit (UART TX path). Outside a dump it passes the pipeline's port-A address and read enable straight through to the bank.

---
 rtl/registers_bank_dump_ctrl.sv | 171 +++++++++++++++++
 tb/tb_registers_bank_dump_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/registers_bank_dump_ctrl.sv
// -----------------------------------------------------------------------------
// registers_bank_dump_ctrl
//
// Purpose:
//   Debug-side controller for the ID-stage register bank. When a dump is
//   requested it stalls the pipeline, takes over bank read port A, and reads
//   every register in ascending address order. Each word is sent LSB byte
//   first over a valid/ready byte stream. Outside a dump, the pipeline's
//   port-A address and read enable pass straight through to the bank.
//
// Optional feature (compile-time macro REGS_DUMP_HEADER_EN):
//   When defined, a single header byte equal to REGISTERS_BANK_SIZE[7:0]
//   is sent before the register data.
//
// Byte stream handshake:
//   A byte transfers on a rising edge where o_byte_valid and i_byte_ready
//   are both high. While o_byte_valid is high and i_byte_ready is low,
//   o_byte holds its value. The stream has no timeout.
//
// Ports:
//   i_clk              system clock, rising edge
//   i_reset            asynchronous active-low reset
//   i_start            dump request, sampled only in IDLE
//   i_pipe_addr_a      pipeline port-A address (pass-through)
//   i_pipe_read_enable pipeline read enable (pass-through)
//   i_bus_a            bank port-A read data
//   i_byte_ready       stream sink ready
//   o_addr_a           address to bank port A
//   o_read_enable      read enable to bank
//   o_byte             stream data
//   o_byte_valid       stream data valid
//   o_stall            pipeline stall request
//   o_busy             dump in progress
//   o_done             one-cycle pulse at dump completion
//   o_dbg_state        current FSM state (debug)
// -----------------------------------------------------------------------------
module registers_bank_dump_ctrl #(
    parameter int REGISTERS_BANK_SIZE = 32,
    parameter int REGISTERS_SIZE      = 32,
    parameter int BYTE_SIZE           = 8
) (
    input  logic                                   i_clk,
    input  logic                                   i_reset,
    input  logic                                   i_start,
    input  logic [$clog2(REGISTERS_BANK_SIZE)-1:0] i_pipe_addr_a,
    input  logic                                   i_pipe_read_enable,
    input  logic [REGISTERS_SIZE-1:0]              i_bus_a,
    input  logic                                   i_byte_ready,
    output logic [$clog2(REGISTERS_BANK_SIZE)-1:0] o_addr_a,
    output logic                                   o_read_enable,
    output logic [BYTE_SIZE-1:0]                   o_byte,
    output logic                                   o_byte_valid,
    output logic                                   o_stall,
    output logic                                   o_busy,
    output logic                                   o_done,
    output logic [2:0]                             o_dbg_state
);

    localparam int ADDR_W = $clog2(REGISTERS_BANK_SIZE);
    localparam int BYTES  = REGISTERS_SIZE / BYTE_SIZE;
    localparam int BIDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    localparam logic [ADDR_W-1:0] LAST_REG  = ADDR_W'(REGISTERS_BANK_SIZE - 1);
    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES - 1);

`ifdef REGS_DUMP_HEADER_EN
    localparam logic [BYTE_SIZE-1:0] HEADER_BYTE = BYTE_SIZE'(REGISTERS_BANK_SIZE);
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_READ   = 3'd1,
        S_LATCH  = 3'd2,
        S_SEND   = 3'd3,
`ifdef REGS_DUMP_HEADER_EN
        S_HEADER = 3'd5,
`endif
        S_DONE   = 3'd4
    } state_e;

    state_e                    state_q, state_d;
    logic [ADDR_W-1:0]         reg_idx_q, reg_idx_d;
    logic [BIDX_W-1:0]         byte_idx_q, byte_idx_d;
    logic [REGISTERS_SIZE-1:0] word_q, word_d;
    logic [REGISTERS_SIZE-1:0] word_shift;

    // Bytes are 8 bits wide, so the byte select is a shift by byte_idx*8.
    assign word_shift = word_q >> {byte_idx_q, 3'b000};

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= S_IDLE;
            reg_idx_q  <= '0;
            byte_idx_q <= '0;
            word_q     <= '0;
        end else begin
            state_q    <= state_d;
            reg_idx_q  <= reg_idx_d;
            byte_idx_q <= byte_idx_d;
            word_q     <= word_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        reg_idx_d     = reg_idx_q;
        byte_idx_d    = byte_idx_q;
        word_d        = word_q;
        o_addr_a      = reg_idx_q;
        o_read_enable = 1'b1;
        o_byte        = '0;
        o_byte_valid  = 1'b0;
        o_done        = 1'b0;

        case (state_q)
            S_IDLE: begin
                o_addr_a      = i_pipe_addr_a;
                o_read_enable = i_pipe_read_enable;
                if (i_start) begin
                    reg_idx_d  = '0;
                    byte_idx_d = '0;
`ifdef REGS_DUMP_HEADER_EN
                    state_d    = S_HEADER;
`else
                    state_d    = S_READ;
`endif
                end
            end
`ifdef REGS_DUMP_HEADER_EN
            S_HEADER: begin
                o_byte_valid = 1'b1;
                o_byte       = HEADER_BYTE;
                if (i_byte_ready) state_d = S_READ;
            end
`endif
            // One cycle of address hold covers both combinational and
            // 1-cycle registered bank reads before the data is captured.
            S_READ: state_d = S_LATCH;
            S_LATCH: begin
                word_d     = i_bus_a;
                byte_idx_d = '0;
                state_d    = S_SEND;
            end
            S_SEND: begin
                o_byte_valid = 1'b1;
                o_byte       = word_shift[BYTE_SIZE-1:0];
                if (i_byte_ready) begin
                    if (byte_idx_q != LAST_BYTE) begin
                        byte_idx_d = byte_idx_q + 1'b1;
                    end else if (reg_idx_q != LAST_REG) begin
                        reg_idx_d = reg_idx_q + 1'b1;
                        state_d   = S_READ;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                o_done  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Derived from the state register, so both drop as soon as reset hits.
    assign o_stall     = (state_q != S_IDLE);
    assign o_busy      = (state_q != S_IDLE);
    assign o_dbg_state = state_q;

endmodule

// File: tb/tb_registers_bank_dump_ctrl.sv
// -----------------------------------------------------------------------------
// tb_registers_bank_dump_ctrl
//
// Bench for registers_bank_dump_ctrl at default parameters. A bank model with
// reg[k] = 32'hA5000000 + k answers port A combinationally. Each dump pushes
// its expected byte sequence into exp_q; a monitor on the falling edge pops
// and compares every accepted byte, checks o_byte holds under backpressure,
// and counts o_done pulses.
// -----------------------------------------------------------------------------
module tb_registers_bank_dump_ctrl;

    localparam int N     = 32;
    localparam int W     = 32;
    localparam int BYTES = W / 8;
`ifdef REGS_DUMP_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    // READ + LATCH + BYTES sends per register, plus the header cycle.
    localparam int DONE_AFTER = N * (2 + BYTES) + HDR;

    // ---------------- clock / reset ----------------
    logic       i_clk = 1'b0;
    logic       i_reset = 1'b0;
    always #5 i_clk = ~i_clk;

    // ---------------- DUT signals ----------------
    logic       i_start = 1'b0;
    logic [4:0] i_pipe_addr_a = '0;
    logic       i_pipe_read_enable = 1'b0;
    logic [W-1:0] i_bus_a;
    logic       i_byte_ready = 1'b0;
    logic [4:0] o_addr_a;
    logic       o_read_enable;
    logic [7:0] o_byte;
    logic       o_byte_valid;
    logic       o_stall;
    logic       o_busy;
    logic       o_done;
    logic [2:0] o_dbg_state;

    logic [W-1:0] bank [N];
    assign i_bus_a = bank[o_addr_a];

    registers_bank_dump_ctrl #(
        .REGISTERS_BANK_SIZE(N),
        .REGISTERS_SIZE(W),
        .BYTE_SIZE(8)
    ) dut (
        .i_clk(i_clk),
        .i_reset(i_reset),
        .i_start(i_start),
        .i_pipe_addr_a(i_pipe_addr_a),
        .i_pipe_read_enable(i_pipe_read_enable),
        .i_bus_a(i_bus_a),
        .i_byte_ready(i_byte_ready),
        .o_addr_a(o_addr_a),
        .o_read_enable(o_read_enable),
        .o_byte(o_byte),
        .o_byte_valid(o_byte_valid),
        .o_stall(o_stall),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_dbg_state(o_dbg_state)
    );

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;
    int rdy_mode = 0;   // 0: ready tied high, 1: random 30% duty

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Ready driver: changes 1 time unit after each rising edge.
    initial begin
        void'($urandom(616563));
        forever begin
            @(posedge i_clk);
            #1;
            if (rdy_mode == 0) i_byte_ready = 1'b1;
            else               i_byte_ready = ($urandom_range(99) < 30);
        end
    end

    // Monitor: samples on the falling edge, away from the active edge.
    logic       hold_prev = 1'b0;
    logic [7:0] byte_prev = '0;
    always @(negedge i_clk) begin
        if (hold_prev) begin
            check("byte_valid_held", {31'd0, o_byte_valid}, 32'd1);
            check("byte_stable", {24'd0, o_byte}, {24'd0, byte_prev});
        end
        if (o_byte_valid && i_byte_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_byte", 32'd1, 32'd0);
            end else begin
                check("stream_byte", {24'd0, o_byte}, {24'd0, exp_q.pop_front()});
            end
        end
        if (o_done) done_cnt++;
        hold_prev = o_byte_valid && !i_byte_ready && i_reset;
        byte_prev = o_byte;
    end

    // ---------------- driver tasks ----------------
    task automatic push_expected();
`ifdef REGS_DUMP_HEADER_EN
        exp_q.push_back(8'h20);
`endif
        for (int k = 0; k < N; k++) begin
            exp_q.push_back(k[7:0]);
            exp_q.push_back(8'h00);
            exp_q.push_back(8'h00);
            exp_q.push_back(8'hA5);
        end
    endtask

    // Runs one dump. restart_at >= 0 re-pulses i_start at that cycle;
    // check_time compares the o_done cycle against DONE_AFTER.
    task automatic do_dump(input int restart_at, input bit check_time);
        int n;
        int done_before;
        done_before = done_cnt;
        push_expected();
        @(negedge i_clk);
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        n = 0;
        check("stall_after_start", {31'd0, o_stall}, 32'd1);
        check("busy_after_start", {31'd0, o_busy}, 32'd1);
        check("read_en_in_dump", {31'd0, o_read_enable}, 32'd1);
        while (!o_done && n < 5000) begin
            @(posedge i_clk);
            #1;
            n++;
            i_start = (n == restart_at);
        end
        i_start = 1'b0;
        check("done_seen", {31'd0, o_done}, 32'd1);
        if (check_time) check("done_cycle", n, DONE_AFTER);
        check("stall_in_done", {31'd0, o_stall}, 32'd1);
        @(posedge i_clk);
        #1;
        check("stall_after_done", {31'd0, o_stall}, 32'd0);
        check("busy_after_done", {31'd0, o_busy}, 32'd0);
        check("passthru_addr", {27'd0, o_addr_a}, {27'd0, i_pipe_addr_a});
        repeat (3) @(posedge i_clk);
        #1;
        check("done_pulses", done_cnt - done_before, 32'd1);
        check("queue_empty", exp_q.size(), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        int done_before;
        for (int k = 0; k < N; k++) bank[k] = 32'hA500_0000 + k;
        i_pipe_addr_a      = 5'd9;
        i_pipe_read_enable = 1'b1;

        // Reset and pass-through
        #12;
        check("rst_valid", {31'd0, o_byte_valid}, 32'd0);
        check("rst_stall", {31'd0, o_stall}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_done", {31'd0, o_done}, 32'd0);
        check("rst_byte", {24'd0, o_byte}, 32'd0);
        i_reset = 1'b1;
        repeat (2) @(posedge i_clk);
        #1;
        check("pt_addr", {27'd0, o_addr_a}, 32'd9);
        check("pt_re", {31'd0, o_read_enable}, 32'd1);
        check("pt_stall", {31'd0, o_stall}, 32'd0);
        i_pipe_read_enable = 1'b0;
        #1;
        check("pt_re_low", {31'd0, o_read_enable}, 32'd0);
        i_pipe_read_enable = 1'b1;

        // Full dump, ready high, timing checked
        rdy_mode = 0;
        do_dump(-1, 1'b1);

        // Start re-pulsed mid-dump at register 5
        do_dump(5 * (2 + BYTES) + HDR, 1'b1);

        // Backpressure
        rdy_mode = 1;
        do_dump(-1, 1'b0);
        rdy_mode = 0;
        repeat (2) @(posedge i_clk);

        // Reset mid-dump during register 3, byte 2
        done_before = done_cnt;
        push_expected();
        @(negedge i_clk);
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        n = 0;
        while (n < 3 * (2 + BYTES) + 4 + HDR) begin
            @(posedge i_clk);
            #1;
            n++;
        end
        check("pre_rst_valid", {31'd0, o_byte_valid}, 32'd1);
        check("pre_rst_byte", {24'd0, o_byte}, 32'd0);
        #1;
        i_reset = 1'b0;
        #1;
        check("abort_valid", {31'd0, o_byte_valid}, 32'd0);
        check("abort_stall", {31'd0, o_stall}, 32'd0);
        check("abort_busy", {31'd0, o_busy}, 32'd0);
        check("abort_addr", {27'd0, o_addr_a}, 32'd9);
        exp_q.delete();
        repeat (3) @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        repeat (3) @(posedge i_clk);
        #1;
        check("abort_no_done", done_cnt - done_before, 32'd0);

        // Fresh dump after the abort starts again at register 0
        do_dump(-1, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global bound so the run always terminates.
    initial begin
        #200000;
        n_checks++;
        n_fail++;
        $display("FAIL global_timeout: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
